// File: rtl/fetch_queue_if.sv
// Bundle of the fetch unit's memory request/response, redirect and decoder channels.
// master = fetch unit side, slave = memory/core environment side.
interface fetch_queue_if;
   logic        o_mem_req_vld;
   logic        i_mem_req_rdy;
   logic [31:0] o_mem_req_addr;
   logic        i_mem_rsp_vld;
   logic [31:0] i_mem_rsp_data;
   logic        i_redirect_vld;
   logic [31:0] i_redirect_pc;
   logic        o_insn_vld;
   logic        i_insn_rdy;
   logic [31:0] o_insn;
   logic [31:0] o_insn_pc;
   logic [31:0] o_stall_cnt;

   modport master (
      output o_mem_req_vld, o_mem_req_addr, o_insn_vld, o_insn, o_insn_pc, o_stall_cnt,
      input  i_mem_req_rdy, i_mem_rsp_vld, i_mem_rsp_data, i_redirect_vld, i_redirect_pc, i_insn_rdy
   );

   modport slave (
      input  o_mem_req_vld, o_mem_req_addr, o_insn_vld, o_insn, o_insn_pc, o_stall_cnt,
      output i_mem_req_rdy, i_mem_rsp_vld, i_mem_rsp_data, i_redirect_vld, i_redirect_pc, i_insn_rdy
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue and in-order memory requests.
// Optional starvation counter on o_stall_cnt is built when FETCH_QUEUE_PERF_EN is defined.
module fetch_queue #(
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input logic           i_clk,
   input logic           i_rst,
   fetch_queue_if.master bus
);
   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never depends on ready; responses carry no backpressure.
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [31:0]   r_fetch_pc;
   logic [CW-1:0] r_wr_ptr;
   logic [CW-1:0] r_rd_ptr;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_drop;
   logic [PW-1:0] r_pf_wr;
   logic [PW-1:0] r_pf_rd;
   logic [31:0]   r_pf_pc  [MAX_OUTSTANDING];
   logic [31:0]   r_q_pc   [DEPTH];
   logic [31:0]   r_q_insn [DEPTH];

   logic [CW-1:0] w_count;
   logic [CW:0]   w_credit_used;
   logic          w_req_vld;
   logic          w_req_fire;
   logic          w_rsp_live;
   logic          w_insn_vld;
   logic          w_deq;
   logic [PW-1:0] w_pf_wr_nxt;
   logic [PW-1:0] w_pf_rd_nxt;
   logic          w_unused;

   assign w_count       = r_wr_ptr - r_rd_ptr;
   // Slots already promised: queued entries plus responses that will still be kept.
   assign w_credit_used = {1'b0, w_count} + {1'b0, r_inflight} - {1'b0, r_drop};
   assign w_req_vld     = !i_rst && !bus.i_redirect_vld
                          && (w_credit_used < (CW+1)'(DEPTH))
                          && (r_inflight < CW'(MAX_OUTSTANDING));
   assign w_req_fire    = w_req_vld && bus.i_mem_req_rdy;
   assign w_rsp_live    = bus.i_mem_rsp_vld && (r_drop == '0) && !bus.i_redirect_vld;
   assign w_insn_vld    = (w_count != '0);
   assign w_deq         = w_insn_vld && bus.i_insn_rdy;
   assign w_pf_wr_nxt   = (r_pf_wr == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_pf_wr + 1'b1;
   assign w_pf_rd_nxt   = (r_pf_rd == PW'(MAX_OUTSTANDING - 1)) ? '0 : r_pf_rd + 1'b1;
   assign w_unused      = ^bus.i_redirect_pc[1:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_fetch_pc <= RESET_PC;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_inflight <= '0;
         r_drop     <= '0;
         r_pf_wr    <= '0;
         r_pf_rd    <= '0;
      end else begin
         r_inflight <= r_inflight + CW'(w_req_fire) - CW'(bus.i_mem_rsp_vld);
         if (w_req_fire)        r_pf_wr <= w_pf_wr_nxt;
         if (bus.i_mem_rsp_vld) r_pf_rd <= w_pf_rd_nxt;
         if (bus.i_redirect_vld) begin
            // A same-cycle dequeue needs no pointer update: the queue is emptied anyway.
            r_fetch_pc <= {bus.i_redirect_pc[31:2], 2'b00};
            r_rd_ptr   <= r_wr_ptr;
            r_drop     <= r_inflight - CW'(bus.i_mem_rsp_vld);
         end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_rsp_live) r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (w_deq)      r_rd_ptr   <= r_rd_ptr + 1'b1;
            if (bus.i_mem_rsp_vld && (r_drop != '0)) r_drop <= r_drop - 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) r_pf_pc[i] <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q_pc[i]   <= '0;
            r_q_insn[i] <= '0;
         end
      end else begin
         if (w_req_fire) r_pf_pc[r_pf_wr] <= r_fetch_pc;
         if (w_rsp_live) begin
            r_q_pc[r_wr_ptr[AW-1:0]]   <= r_pf_pc[r_pf_rd];
            r_q_insn[r_wr_ptr[AW-1:0]] <= bus.i_mem_rsp_data;
         end
      end
   end

   assign bus.o_mem_req_vld  = w_req_vld;
   assign bus.o_mem_req_addr = r_fetch_pc;
   assign bus.o_insn_vld     = w_insn_vld;
   assign bus.o_insn         = r_q_insn[r_rd_ptr[AW-1:0]];
   assign bus.o_insn_pc      = r_q_pc[r_rd_ptr[AW-1:0]];

`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
      end else if (bus.i_insn_rdy && !w_insn_vld && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign bus.o_stall_cnt = r_stall_cnt;
`else
   assign bus.o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order variable-latency memory, random stimulus, and a reference
// model built from outstanding-request and expected-instruction queues.
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam int          MAXO     = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fetch_queue_if bus();

   fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int mem_lat     = 1;
   int mem_rdy_pct = 100;

   logic [31:0] pend_addr[$];
   int          pend_due[$];

   logic [31:0] m_pc;
   logic [31:0] out_pc[$];
   bit          out_stale[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc_q[$];
   logic [31:0] m_stall;

   bit          l_req_vld;
   bit          l_req_fire;
   logic [31:0] l_req_addr;
   bit          l_deq;
   logic [31:0] l_deq_pc;
   logic [31:0] l_deq_insn;
   bit          l_rsp;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.i_mem_req_rdy  = 1'b0;
      bus.i_mem_rsp_vld  = 1'b0;
      bus.i_mem_rsp_data = '0;
      bus.i_redirect_vld = 1'b0;
      bus.i_redirect_pc  = '0;
      bus.i_insn_rdy     = 1'b0;
      pend_addr.delete();
      pend_due.delete();
      out_pc.delete();
      out_stale.delete();
      exp_q.delete();
      exp_pc_q.delete();
      m_pc    = RESET_PC;
      m_stall = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc = 0;
   endtask

   // One clock cycle: drive at the falling edge, check just after, then advance the model.
   task automatic tick(input bit irdy, input bit rdr, input logic [31:0] rpc);
      int          live;
      int          due;
      bit          exp_vld;
      bit          exp_req;
      logic [31:0] exp_stall;
      logic [31:0] hpc;
      bit          hstale;
      bus.i_mem_req_rdy = ($urandom_range(99) < mem_rdy_pct);
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         bus.i_mem_rsp_vld  = 1'b1;
         bus.i_mem_rsp_data = mem_word(pend_addr[0]);
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         bus.i_mem_rsp_vld  = 1'b0;
         bus.i_mem_rsp_data = $urandom;
      end
      bus.i_insn_rdy     = irdy;
      bus.i_redirect_vld = rdr;
      bus.i_redirect_pc  = rpc;
      #1;
      live = 0;
      foreach (out_stale[i]) if (!out_stale[i]) live++;
      exp_vld = (exp_pc_q.size() != 0);
      exp_req = !rdr && ((exp_pc_q.size() + live) < DEPTH) && (out_pc.size() < MAXO);
`ifdef FETCH_QUEUE_PERF_EN
      exp_stall = m_stall;
`else
      exp_stall = '0;
`endif
      total++;
      if (bus.o_insn_vld !== exp_vld) begin
         bad++;
         $display("FAIL insn_vld cyc=%0d got=%0b exp=%0b", cyc, bus.o_insn_vld, exp_vld);
      end
      total++;
      if (bus.o_mem_req_vld !== exp_req) begin
         bad++;
         $display("FAIL req_vld cyc=%0d got=%0b exp=%0b", cyc, bus.o_mem_req_vld, exp_req);
      end
      total++;
      if (bus.o_stall_cnt !== exp_stall) begin
         bad++;
         $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", cyc, bus.o_stall_cnt, exp_stall);
      end
      l_req_vld  = bus.o_mem_req_vld;
      l_req_fire = bus.o_mem_req_vld && bus.i_mem_req_rdy;
      l_req_addr = bus.o_mem_req_addr;
      if (l_req_fire) begin
         total++;
         if (l_req_addr !== m_pc) begin
            bad++;
            $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, l_req_addr, m_pc);
         end
      end
      l_deq      = bus.o_insn_vld && irdy;
      l_deq_pc   = bus.o_insn_pc;
      l_deq_insn = bus.o_insn;
      if (l_deq) begin
         total++;
         if (exp_pc_q.size() == 0) begin
            bad++;
            $display("FAIL deq_unexpected cyc=%0d got_pc=%h exp=none", cyc, l_deq_pc);
         end else begin
            if (l_deq_pc !== exp_pc_q[0] || l_deq_insn !== exp_q[0]) begin
               bad++;
               $display("FAIL deq cyc=%0d got=%h/%h exp=%h/%h", cyc, l_deq_pc, l_deq_insn,
                        exp_pc_q[0], exp_q[0]);
            end
            void'(exp_pc_q.pop_front());
            void'(exp_q.pop_front());
         end
      end
      l_rsp = bus.i_mem_rsp_vld;
      if (l_rsp) begin
         total++;
         if (out_pc.size() == 0) begin
            bad++;
            $display("FAIL rsp_without_request cyc=%0d got=rsp exp=none", cyc);
         end else begin
            hpc    = out_pc.pop_front();
            hstale = out_stale.pop_front();
            if (!hstale && !rdr) begin
               exp_pc_q.push_back(hpc);
               exp_q.push_back(mem_word(hpc));
            end
         end
      end
      if (l_req_fire) begin
         out_pc.push_back(m_pc);
         out_stale.push_back(1'b0);
         due = cyc + mem_lat;
         if (pend_due.size() > 0 && pend_due[$] >= due) due = pend_due[$] + 1;
         pend_addr.push_back(l_req_addr);
         pend_due.push_back(due);
         m_pc = m_pc + 32'd4;
      end
      if (rdr) begin
         foreach (out_stale[i]) out_stale[i] = 1'b1;
         exp_q.delete();
         exp_pc_q.delete();
         m_pc = {rpc[31:2], 2'b00};
      end
      if (irdy && !exp_vld && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      cyc++;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.i_mem_req_rdy  = 1'b1;
      bus.i_mem_rsp_vld  = 1'b0;
      bus.i_mem_rsp_data = '0;
      bus.i_redirect_vld = 1'b0;
      bus.i_redirect_pc  = '0;
      bus.i_insn_rdy     = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (bus.o_mem_req_vld !== 1'b0) begin bad++; $display("FAIL rst_req_vld got=%b exp=0", bus.o_mem_req_vld); end
      total++;
      if (bus.o_mem_req_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr got=%h exp=%h", bus.o_mem_req_addr, RESET_PC); end
      total++;
      if (bus.o_insn_vld !== 1'b0) begin bad++; $display("FAIL rst_insn_vld got=%b exp=0", bus.o_insn_vld); end
      total++;
      if (bus.o_insn !== 32'h0) begin bad++; $display("FAIL rst_insn got=%h exp=0", bus.o_insn); end
      total++;
      if (bus.o_insn_pc !== 32'h0) begin bad++; $display("FAIL rst_insn_pc got=%h exp=0", bus.o_insn_pc); end
      total++;
      if (bus.o_stall_cnt !== 32'h0) begin bad++; $display("FAIL rst_stall got=%h exp=0", bus.o_stall_cnt); end
   endtask

   task automatic test_stream();
      do_reset();
      mem_lat = 1;
      mem_rdy_pct = 100;
      for (int k = 0; k < 20; k++) begin
         tick(1'b1, 1'b0, '0);
         if (k < 4) begin
            total++;
            if (!l_req_fire || l_req_addr !== 32'(4 * k)) begin
               bad++;
               $display("FAIL stream_req k=%0d got=%0b/%h exp=1/%h", k, l_req_fire, l_req_addr, 32'(4 * k));
            end
         end
         if (k >= 2) begin
            total++;
            if (!l_deq || l_deq_pc !== 32'(4 * (k - 2))) begin
               bad++;
               $display("FAIL stream_deq k=%0d got=%0b/%h exp=1/%h", k, l_deq, l_deq_pc, 32'(4 * (k - 2)));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int          n_req;
      int          n_rsp;
      logic [31:0] got[$];
      do_reset();
      mem_lat = $urandom_range(1, 3);
      mem_rdy_pct = 100;
      n_req = 0;
      n_rsp = 0;
      for (int k = 0; k < 15; k++) begin
         tick(1'b0, 1'b0, '0);
         if (l_req_fire) n_req++;
         if (l_rsp) n_rsp++;
      end
      total++;
      if (n_req != DEPTH) begin bad++; $display("FAIL bp_requests got=%0d exp=%0d", n_req, DEPTH); end
      total++;
      if (n_rsp != DEPTH) begin bad++; $display("FAIL bp_responses got=%0d exp=%0d", n_rsp, DEPTH); end
      total++;
      if (bus.o_mem_req_vld !== 1'b0) begin bad++; $display("FAIL bp_req_held got=%b exp=0", bus.o_mem_req_vld); end
      for (int k = 0; k < 20; k++) begin
         tick(1'b1, 1'b0, '0);
         if (l_deq) got.push_back(l_deq_pc);
      end
      total++;
      if (got.size() < 8) begin
         bad++;
         $display("FAIL bp_drain_count got=%0d exp>=8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            total++;
            if (got[i] !== 32'(4 * i)) begin
               bad++;
               $display("FAIL bp_order i=%0d got=%h exp=%h", i, got[i], 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_redirect_drop();
      bit found;
      do_reset();
      mem_lat = 3;
      mem_rdy_pct = 100;
      tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b0, '0);
      total++;
      if (out_pc.size() != 2) begin bad++; $display("FAIL drop_setup got=%0d exp=2", out_pc.size()); end
      tick(1'b1, 1'b1, 32'h0000_0100);
      total++;
      if (l_rsp) begin bad++; $display("FAIL drop_rsp_timing got=1 exp=0"); end
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         tick(1'b1, 1'b0, '0);
         if (l_deq) begin
            found = 1'b1;
            total++;
            if (l_deq_pc !== 32'h100 || l_deq_insn !== mem_word(32'h100)) begin
               bad++;
               $display("FAIL drop_first got=%h/%h exp=%h/%h", l_deq_pc, l_deq_insn, 32'h100, mem_word(32'h100));
            end
         end
      end
      if (!found) begin total++; bad++; $display("FAIL drop_timeout got=none exp=insn"); end
   endtask

   task automatic test_redirect_collision();
      do_reset();
      mem_lat = 1;
      mem_rdy_pct = 100;
      repeat (6) tick(1'b1, 1'b0, '0);
      tick(1'b1, 1'b1, 32'h0000_0203);
      total++;
      if (!l_rsp || !l_deq || l_deq_pc !== 32'h10) begin
         bad++;
         $display("FAIL coll_cycle got=rsp%0b deq%0b pc=%h exp=rsp1 deq1 pc=00000010", l_rsp, l_deq, l_deq_pc);
      end
      total++;
      if (l_req_vld) begin bad++; $display("FAIL coll_req_vld got=1 exp=0"); end
      tick(1'b1, 1'b0, '0);
      total++;
      if (!l_req_fire || l_req_addr !== 32'h200) begin
         bad++;
         $display("FAIL coll_next_req got=%0b/%h exp=1/00000200", l_req_fire, l_req_addr);
      end
      tick(1'b1, 1'b0, '0);
      total++;
      if (l_deq) begin bad++; $display("FAIL coll_gap got=deq pc=%h exp=none", l_deq_pc); end
      tick(1'b1, 1'b0, '0);
      total++;
      if (!l_deq || l_deq_pc !== 32'h200) begin
         bad++;
         $display("FAIL coll_next_deq got=%0b/%h exp=1/00000200", l_deq, l_deq_pc);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] addrs[$];
      logic [31:0] want[4];
      do_reset();
      mem_lat = 1;
      mem_rdy_pct = 100;
      want[0] = 32'hFFFF_FFF8;
      want[1] = 32'hFFFF_FFFC;
      want[2] = 32'h0000_0000;
      want[3] = 32'h0000_0004;
      tick(1'b1, 1'b1, 32'hFFFF_FFF9);
      for (int k = 0; k < 20 && addrs.size() < 4; k++) begin
         tick(1'b1, 1'b0, '0);
         if (l_req_fire) addrs.push_back(l_req_addr);
      end
      total++;
      if (addrs.size() != 4) begin
         bad++;
         $display("FAIL wrap_count got=%0d exp=4", addrs.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (addrs[i] !== want[i]) begin
               bad++;
               $display("FAIL wrap_addr i=%0d got=%h exp=%h", i, addrs[i], want[i]);
            end
         end
      end
   endtask

   task automatic test_perf();
      logic [31:0] exp10;
      logic [31:0] exp11;
`ifdef FETCH_QUEUE_PERF_EN
      exp10 = 32'd10;
      exp11 = 32'd11;
`else
      exp10 = 32'd0;
      exp11 = 32'd0;
`endif
      do_reset();
      mem_rdy_pct = 0;
      repeat (10) tick(1'b1, 1'b0, '0);
      total++;
      if (bus.o_stall_cnt !== exp10) begin bad++; $display("FAIL perf_10 got=%0d exp=%0d", bus.o_stall_cnt, exp10); end
      tick(1'b0, 1'b1, 32'h0000_0040);
      total++;
      if (bus.o_stall_cnt !== exp10) begin bad++; $display("FAIL perf_redirect got=%0d exp=%0d", bus.o_stall_cnt, exp10); end
      tick(1'b1, 1'b0, '0);
      total++;
      if (bus.o_stall_cnt !== exp11) begin bad++; $display("FAIL perf_11 got=%0d exp=%0d", bus.o_stall_cnt, exp11); end
      mem_rdy_pct = 100;
   endtask

   task automatic test_random();
      bit          irdy;
      bit          rdr;
      logic [31:0] rpc;
      do_reset();
      mem_rdy_pct = 70;
      for (int k = 0; k < 800; k++) begin
         if (k % 100 == 0) mem_lat = $urandom_range(1, 4);
         irdy = ($urandom_range(0, 3) != 0);
         rdr  = ($urandom_range(0, 29) == 0);
         rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         tick(irdy, rdr, rpc);
      end
      mem_rdy_pct = 100;
   endtask

   task automatic test_async_reset();
      mem_lat = 2;
      repeat (8) tick(1'b0, 1'b0, '0);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (bus.o_insn_vld !== 1'b0 || bus.o_mem_req_vld !== 1'b0) begin
         bad++;
         $display("FAIL areset_vld got=%b%b exp=00", bus.o_insn_vld, bus.o_mem_req_vld);
      end
      total++;
      if (bus.o_mem_req_addr !== RESET_PC || bus.o_insn_pc !== 32'h0) begin
         bad++;
         $display("FAIL areset_state got=%h/%h exp=%h/0", bus.o_mem_req_addr, bus.o_insn_pc, RESET_PC);
      end
      do_reset();
      mem_lat = 1;
      repeat (3) tick(1'b1, 1'b0, '0);
      total++;
      if (!l_deq || l_deq_pc !== RESET_PC) begin
         bad++;
         $display("FAIL areset_restart got=%0b/%h exp=1/%h", l_deq, l_deq_pc, RESET_PC);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_redirect_collision();
      test_wrap();
      test_perf();
      test_random();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
